// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, ALU function and FSM state encodings for the multi-cycle core
package cpu_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  typedef enum logic [2:0] {
    FS_ADD  = 3'd0,
    FS_SUB  = 3'd1,
    FS_SLL  = 3'd2,
    FS_SRL  = 3'd3,
    FS_XOR  = 3'd4,
    FS_AND  = 3'd5,
    FS_OR   = 3'd6,
    FS_PASS = 3'd7
  } fs_t;
  localparam logic [3:0] OP_RNW  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_R    = 4'hF;
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: 8 x DW register file, two asynchronous read ports, one synchronous write port
module cpu_regfile #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET_L,
  input  logic [2:0]    ra_sel,
  input  logic [2:0]    rb_sel,
  input  logic          we,
  input  logic [2:0]    wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] ra,
  output logic [DW-1:0] rb
);
  logic [DW-1:0] r [8];
  // single write port; R0 is an ordinary register
  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L)
      for (int i = 0; i < 8; i++) r[i] <= '0;
    else if (we)
      r[wa] <= wd;
  assign ra = r[ra_sel];
  assign rb = r[rb_sel];
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle 16-bit-instruction core with handshaked instruction and data ports
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int PC_STEP = 2
) (
  input  logic          CLK,
  input  logic          RESET_L,
  input  logic          EN_L,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic [15:0]   IIN,
  input  logic          IVALID,
  output logic          DREQ,
  output logic          DWE,
  output logic [AW-1:0] DADDR,
  output logic [DW-1:0] DOUT,
  input  logic [DW-1:0] DIN,
  input  logic          DVALID,
  output logic [AW-1:0] PC,
  output logic [2:0]    STATE,
  output logic          HALTED
);
  state_t        state;
  fs_t           fn;
  logic [15:0]   ir;
  logic [3:0]    op;
  logic [DW-1:0] a, b, imm, y, opb, res, ra, rb;
  logic [AW-1:0] npc, seq_pc, br_pc;
  logic          wr, take;
  logic [2:0]    wa;
  assign op     = ir[15:12];
  assign wr     = op == OP_R || op == OP_LD || op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
  assign wa     = op == OP_R ? ir[5:3] : ir[8:6];
  assign opb    = op == OP_R || op == OP_RNW ? b : imm;
  assign fn     = op == OP_ADDI ? FS_ADD : op == OP_ANDI ? FS_AND : op == OP_ORI ? FS_OR : fs_t'(ir[2:0]);
  assign take   = op == OP_JMP || (op == OP_BEQ && a == b) || (op == OP_BNE && a != b);
  assign seq_pc = PC + AW'(PC_STEP);
  assign br_pc  = seq_pc + (AW'($signed(ir[5:0])) << 1);
  cpu_regfile #(.DW(DW)) u_rf (
    .CLK    (CLK),
    .RESET_L(RESET_L),
    .ra_sel (ir[11:9]),
    .rb_sel (ir[8:6]),
    .we     (state == S_WB && wr),
    .wa     (wa),
    .wd     (y),
    .ra     (ra),
    .rb     (rb)
  );
  // ALU; immediate ops reuse it with IMM as the second operand
  always_comb
    case (fn)
      FS_ADD:  res = a + opb;
      FS_SUB:  res = a - opb;
      FS_SLL:  res = {a[DW-2:0], 1'b0};
      FS_SRL:  res = {1'b0, a[DW-1:1]};
      FS_XOR:  res = a ^ opb;
      FS_AND:  res = a & opb;
      FS_OR:   res = a | opb;
      default: res = a;
    endcase
  // sequencer: fetch, decode, execute, optional memory access, write-back; HALT is terminal
  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) begin
      state <= S_FETCH;
      PC    <= '0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      imm   <= '0;
      y     <= '0;
      npc   <= '0;
    end else
      case (state)
        S_FETCH:
          if (IREQ && IVALID) begin
            ir    <= IIN;
            state <= S_DECODE;
          end
        S_DECODE: begin
          a     <= ra;
          b     <= rb;
          imm   <= DW'($signed(ir[5:0]));
          state <= S_EXEC;
        end
        S_EXEC: begin
          y     <= res;
          npc   <= take ? br_pc : seq_pc;
          state <= op == OP_LD || op == OP_ST ? S_MEM : op == OP_HALT ? S_HALT : S_WB;
        end
        S_MEM:
          if (DVALID) begin
            y     <= DWE ? y : DIN;
            state <= S_WB;
          end
        S_WB: begin
          PC    <= npc;
          state <= S_FETCH;
        end
        default: state <= state;
      endcase
  assign IREQ   = state == S_FETCH && !EN_L && RESET_L;
  assign IADDR  = PC;
  assign DREQ   = state == S_MEM;
  assign DWE    = DREQ && op == OP_ST;
  assign DADDR  = AW'(a + imm);
  assign DOUT   = b;
  assign STATE  = state;
  assign HALTED = state == S_HALT;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: ISA-level reference model with randomized memory wait states and run enable
module tb_multicycle_cpu;
  import cpu_pkg::*;
  logic        CLK = 0, RESET_L = 0, EN_L = 1, IVALID = 0, DVALID = 0;
  logic [15:0] IIN = '0;
  logic [7:0]  DIN = '0;
  logic        IREQ, DREQ, DWE, HALTED;
  logic [7:0]  IADDR, DADDR, DOUT, PC;
  logic [2:0]  STATE;

  multicycle_cpu dut (
    .CLK(CLK), .RESET_L(RESET_L), .EN_L(EN_L),
    .IREQ(IREQ), .IADDR(IADDR), .IIN(IIN), .IVALID(IVALID),
    .DREQ(DREQ), .DWE(DWE), .DADDR(DADDR), .DOUT(DOUT), .DIN(DIN), .DVALID(DVALID),
    .PC(PC), .STATE(STATE), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic we; logic [7:0] addr; logic [7:0] data; } acc_t;
  typedef struct { logic [3:0] op; logic [2:0] fs; logic [7:0] a, b; logic [5:0] imm; logic [7:0] exp; } vec_t;

  int total = 0, bad = 0, cyc = 0;
  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  acc_t        eq[$], dlog[$];
  logic [7:0]  flog[$];
  logic [7:0]  m_r [8];
  logic [7:0]  m_pc;
  bit          m_halt, auto_on, rnd_en, lat_chk, have_prev, last_mem;
  int          last_cyc, last_dw, iw_fix = -1, dw_fix = -1;
  bit          ip, dp;
  int          iw, dw, icy, dwu;
  logic [7:0]  ia, da, dd;
  logic        dwe_s;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] enc(logic [3:0] op, logic [2:0] ra, logic [2:0] rb, logic [5:0] imm);
    return {op, ra, rb, imm};
  endfunction

  function automatic logic [7:0] alu_ref(logic [2:0] fs, logic [7:0] x, logic [7:0] y);
    case (fs)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return 8'(int'(x) * 2);
      3'd3: return 8'(int'(x) / 2);
      3'd4: return x ^ y;
      3'd5: return x & y;
      3'd6: return x | y;
      default: return x;
    endcase
  endfunction

  // executes one whole instruction at ISA level when its fetch completes
  task automatic model_fetch(logic [7:0] addr, logic [15:0] w, int waits);
    logic [7:0] x, y, ea, nxt;
    int simm;
    chk("fetch_pc", addr, m_pc);
    chk("fetch_after_halt", m_halt, 0);
    if (lat_chk && have_prev) chk("latency", cyc - last_cyc, 4 + (last_mem ? 1 + last_dw : 0) + waits);
    have_prev = 1; last_cyc = cyc; last_dw = 0;
    x = m_r[w[11:9]]; y = m_r[w[8:6]];
    simm = $signed(w[5:0]);
    ea = 8'(int'(x) + simm);
    nxt = 8'(int'(m_pc) + 2);
    last_mem = w[15:12] == 4'h2 || w[15:12] == 4'h4;
    case (w[15:12])
      4'hF: m_r[w[5:3]] = alu_ref(w[2:0], x, y);
      4'h2: begin eq.push_back('{1'b0, ea, 8'h00}); m_r[w[8:6]] = dmem[ea]; end
      4'h4: eq.push_back('{1'b1, ea, y});
      4'h5: m_r[w[8:6]] = 8'(int'(x) + simm);
      4'h6: m_r[w[8:6]] = x & 8'(simm);
      4'h7: m_r[w[8:6]] = x | 8'(simm);
      4'h8: if (x == y) nxt = 8'(int'(nxt) + 2 * simm);
      4'h9: if (x != y) nxt = 8'(int'(nxt) + 2 * simm);
      4'hA: nxt = 8'(int'(nxt) + 2 * simm);
      4'h1: m_halt = 1;
      default: ;
    endcase
    if (!m_halt) m_pc = nxt;
  endtask

  // memory responders: random or fixed wait states, stability checks while waiting
  task automatic serve();
    acc_t e;
    if (EN_L) chk("ireq_gated", IREQ, 0);
    if (IREQ !== 1'b1) begin
      IVALID = 0; ip = 0;
    end else begin
      if (!ip) begin ip = 1; iw = iw_fix >= 0 ? iw_fix : $urandom_range(0, 3); icy = 0; ia = IADDR; end
      else chk("iaddr_stable", IADDR, ia);
      if (icy == iw) begin
        IVALID = 1; IIN = imem[IADDR]; flog.push_back(IADDR);
        model_fetch(IADDR, imem[IADDR], iw);
        ip = 0;
      end else begin
        IVALID = 0; IIN = 16'h1000;
        chk("fetch_wait_state", STATE, S_FETCH);
      end
      icy++;
    end
    if (DREQ !== 1'b1) begin
      DVALID = 0; dp = 0;
    end else begin
      if (!dp) begin dp = 1; dw = dw_fix >= 0 ? dw_fix : $urandom_range(0, 3); dwu = dw; da = DADDR; dd = DOUT; dwe_s = DWE; end
      else begin chk("daddr_stable", DADDR, da); chk("dout_stable", DOUT, dd); chk("dwe_stable", DWE, dwe_s); end
      if (dw == 0) begin
        DVALID = 1; dlog.push_back('{DWE, DADDR, DOUT});
        chk("data_access_expected", eq.size() > 0, 1);
        if (eq.size() > 0) begin
          e = eq.pop_front();
          chk("dwe", DWE, e.we); chk("daddr", DADDR, e.addr);
          if (e.we) chk("dout", DOUT, e.data);
        end
        if (DWE) dmem[DADDR] = DOUT; else DIN = dmem[DADDR];
        last_dw = dwu; dp = 0;
      end else begin
        DVALID = 0; DIN = 8'($urandom); dw--;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (rnd_en) EN_L = $urandom_range(0, 4) == 0;
    #1;
    if (auto_on) serve();
  endtask

  task automatic do_reset();
    RESET_L = 0; IVALID = 0; DVALID = 0;
    repeat (2) tick();
    ip = 0; dp = 0; eq.delete(); dlog.delete(); flog.delete();
    m_pc = 0; m_halt = 0; have_prev = 0;
    foreach (m_r[i]) m_r[i] = 0;
    RESET_L = 1;
  endtask

  task automatic run_halt(string name, int max);
    int n = 0;
    while (HALTED !== 1'b1 && n < max) begin tick(); n++; end
    chk(name, HALTED, 1);
  endtask

  task automatic clear_imem();
    foreach (imem[i]) imem[i] = 16'h3000;
  endtask

  vec_t vt[13];
  logic [7:0] exp4[5];
  int n, nreq;

  initial begin
    foreach (dmem[i]) dmem[i] = 8'($urandom);
    clear_imem();
    auto_on = 0; rnd_en = 0; lat_chk = 1; EN_L = 0; RESET_L = 0;
    repeat (2) tick();
    chk("rst_pc", PC, 0); chk("rst_state", STATE, S_FETCH); chk("rst_ireq", IREQ, 0);
    chk("rst_dreq", DREQ, 0); chk("rst_dwe", DWE, 0); chk("rst_halted", HALTED, 0); chk("rst_dout", DOUT, 0);
    auto_on = 1;

    // zero-wait ADDI then store to observe R1
    iw_fix = 0; dw_fix = 0; do_reset();
    imem[0] = enc(4'h5, 0, 1, 6'd5); imem[2] = enc(4'h4, 0, 1, 0); imem[4] = enc(4'h1, 0, 0, 0);
    run_halt("t1_halt", 60);
    chk("t1_nfetch", flog.size(), 3);
    if (flog.size() == 3) begin chk("t1_iaddr0", flog[0], 8'h00); chk("t1_iaddr1", flog[1], 8'h02); end
    if (dlog.size() == 1) chk("t1_r1", dlog[0].data, 8'd5);

    // instruction wait states; IIN carries a HALT word until IVALID
    iw_fix = 3; do_reset(); clear_imem();
    imem[0] = enc(4'h5, 0, 1, 6'd7); imem[2] = enc(4'h4, 0, 1, 0); imem[4] = enc(4'h1, 0, 0, 0);
    run_halt("t2_halt", 80);
    chk("t2_nstore", dlog.size(), 1);
    if (dlog.size() == 1) chk("t2_r1", dlog[0].data, 8'd7);

    // store then load through R1+1 with two data wait states
    iw_fix = 0; dw_fix = 2; do_reset(); clear_imem();
    imem[0] = enc(4'h5, 0, 1, 6'd5); imem[2] = enc(4'h5, 0, 2, 6'd13);
    imem[4] = enc(4'h4, 1, 2, 6'd1); imem[6] = enc(4'h2, 1, 3, 6'd1);
    imem[8] = enc(4'h4, 0, 3, 0); imem[10] = enc(4'h1, 0, 0, 0);
    run_halt("t3_halt", 120);
    chk("t3_naccess", dlog.size(), 3);
    if (dlog.size() == 3) begin
      chk("t3_st_we", dlog[0].we, 1); chk("t3_st_addr", dlog[0].addr, 8'd6); chk("t3_st_data", dlog[0].data, 8'd13);
      chk("t3_ld_we", dlog[1].we, 0); chk("t3_ld_addr", dlog[1].addr, 8'd6); chk("t3_r3", dlog[2].data, 8'd13);
    end

    // taken BEQ backwards, then not-taken BNE and a PC wrap past 0xFE
    dw_fix = 0; do_reset(); clear_imem();
    imem[8'h00] = enc(4'hA, 0, 0, 6'd7); imem[8'h10] = enc(4'h8, 1, 1, 6'h3E); imem[8'h0E] = enc(4'h1, 0, 0, 0);
    run_halt("t4_beq_halt", 60);
    chk("t4_beq_pc", PC, 8'h0E);
    do_reset(); clear_imem();
    imem[8'h00] = enc(4'hA, 0, 0, 6'd7); imem[8'h10] = enc(4'h9, 1, 1, 6'h3E); imem[8'h12] = enc(4'hA, 0, 0, 6'h35);
    n = 0;
    while (flog.size() < 5 && n < 100) begin tick(); n++; end
    exp4 = '{8'h00, 8'h10, 8'h12, 8'hFE, 8'h00};
    chk("t4_nfetch", flog.size() >= 5, 1);
    for (int i = 0; i < 5 && i < flog.size(); i++) chk($sformatf("t4_fetch%0d", i), flog[i], exp4[i]);

    // EN_L raised during EXEC: instruction retires, then fetch stalls until EN_L drops
    iw_fix = -1; dw_fix = -1; lat_chk = 0; do_reset(); clear_imem();
    imem[0] = enc(4'h5, 0, 1, 6'd3); imem[2] = enc(4'h4, 0, 1, 0); imem[4] = enc(4'h1, 0, 0, 0);
    n = 0;
    while (STATE !== S_EXEC && n < 20) begin tick(); n++; end
    chk("t5_exec", STATE, S_EXEC);
    EN_L = 1;
    repeat (10) tick();
    chk("t5_state", STATE, S_FETCH); chk("t5_pc", PC, 8'h02); chk("t5_nfetch", flog.size(), 1);
    EN_L = 0;
    run_halt("t5_halt", 80);
    if (dlog.size() == 1) chk("t5_r1", dlog[0].data, 8'd3);
    lat_chk = 1;

    // HALT is terminal
    do_reset(); clear_imem();
    imem[0] = enc(4'h1, 0, 0, 0);
    run_halt("t6_halt", 40);
    nreq = 0;
    repeat (20) begin tick(); nreq += int'(IREQ); end
    chk("t6_no_ireq", nreq, 0); chk("t6_still_halted", HALTED, 1);

    // reset during a stalled load; a late DVALID must be ignored
    dw_fix = 6; do_reset(); clear_imem();
    imem[0] = enc(4'h2, 0, 1, 6'd4);
    n = 0;
    while (DREQ !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t6_dreq_seen", DREQ, 1);
    repeat (2) tick();
    RESET_L = 0; #1;
    chk("t6_rst_dreq", DREQ, 0); chk("t6_rst_pc", PC, 0); chk("t6_rst_state", STATE, S_FETCH);
    auto_on = 0; EN_L = 1; #1 RESET_L = 1;
    DVALID = 1; DIN = 8'hAA;
    repeat (3) tick();
    chk("t6_late_state", STATE, S_FETCH); chk("t6_late_dreq", DREQ, 0); chk("t6_late_pc", PC, 0);
    DVALID = 0; EN_L = 0; auto_on = 1; dw_fix = -1;

    // ALU / immediate / no-write vectors: LD R1,[0]; LD R2,[1]; op; ST R3,[2]; HALT
    vt = '{
      '{4'hF, 3'd0, 8'h7F, 8'h81, 6'h00, 8'h00},
      '{4'hF, 3'd1, 8'h10, 8'h20, 6'h00, 8'hF0},
      '{4'hF, 3'd2, 8'h81, 8'h00, 6'h00, 8'h02},
      '{4'hF, 3'd3, 8'h81, 8'h00, 6'h00, 8'h40},
      '{4'hF, 3'd4, 8'hF0, 8'h3C, 6'h00, 8'hCC},
      '{4'hF, 3'd5, 8'hF0, 8'h3C, 6'h00, 8'h30},
      '{4'hF, 3'd6, 8'hF0, 8'h3C, 6'h00, 8'hFC},
      '{4'hF, 3'd7, 8'h5A, 8'hFF, 6'h00, 8'h5A},
      '{4'h5, 3'd0, 8'h10, 8'h00, 6'h3F, 8'h0F},
      '{4'h6, 3'd0, 8'hFF, 8'h00, 6'h20, 8'hE0},
      '{4'h7, 3'd0, 8'h01, 8'h00, 6'h1F, 8'h1F},
      '{4'h0, 3'd0, 8'h01, 8'h02, 6'h00, 8'h00},
      '{4'h3, 3'd0, 8'h01, 8'h02, 6'h3F, 8'h00}
    };
    for (int i = 0; i < 13; i++) begin
      do_reset(); clear_imem();
      dmem[0] = vt[i].a; dmem[1] = vt[i].b;
      imem[0] = enc(4'h2, 0, 1, 0); imem[2] = enc(4'h2, 0, 2, 6'd1);
      imem[4] = vt[i].op == 4'hF || vt[i].op == 4'h0 ? enc(vt[i].op, 1, 2, {3'd3, vt[i].fs}) : enc(vt[i].op, 1, 3, vt[i].imm);
      imem[6] = enc(4'h4, 0, 3, 6'd2); imem[8] = enc(4'h1, 0, 0, 0);
      run_halt($sformatf("vec%0d_halt", i), 120);
      chk($sformatf("vec%0d_result", i), dlog.size() > 0 ? dlog[dlog.size()-1].data : 8'hxx, vt[i].exp);
    end

    // random programs (no HALT) against the ISA model
    do_reset();
    for (int i = 0; i < 256; i += 2) begin
      imem[i] = 16'($urandom);
      if (imem[i][15:12] == 4'h1) imem[i][15:12] = 4'h5;
    end
    repeat (2000) tick();
    lat_chk = 0; rnd_en = 1;
    repeat (2000) tick();
    rnd_en = 0; EN_L = 0;
    chk("rand_progress", flog.size() > 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
